// File: rtl/compressor_jp_pkg.sv
// compressor_jp_pkg: shared constants, flush state type and width helper for the JPEG output path
package compressor_jp_pkg;
    localparam logic [7:0] ESC_BYTE_DEF   = 8'hff;
    localparam logic [7:0] STUFF_BYTE_DEF = 8'h00;
    typedef enum logic [1:0] {FS_IDLE, FS_FLUSH, FS_DONE} flush_st_e;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/bit_stuffer_escape_expand.sv
// bit_stuffer_escape_expand: expands one word into an MSB-aligned byte vector with stuff bytes inserted
module bit_stuffer_escape_expand
    import compressor_jp_pkg::*;
#(
    parameter int NB = 4,
    parameter logic [7:0] ESC_BYTE = ESC_BYTE_DEF,
    parameter logic [7:0] STUFF_BYTE = STUFF_BYTE_DEF,
    localparam int BW = clog2(NB),
    localparam int AW = clog2(2*NB+1),
    localparam int SW = clog2(NB+1)
) (
    input  logic [8*NB-1:0]  din,
    input  logic [BW-1:0]    bytes_in,
    input  logic             escape_en,
    output logic [16*NB-1:0] exp_bytes,
    output logic [AW-1:0]    add_cnt,
    output logic [SW-1:0]    stuff_cnt
);
    int n, s, nv;
    always_comb begin
        exp_bytes = '0;
        n = 0;
        s = 0;
        nv = (bytes_in == '0) ? NB : int'(bytes_in);
        for (int i = 0; i < NB; i++) begin
            if (i < nv) begin
                exp_bytes[8*(2*NB-1-n) +: 8] = din[8*(NB-1-i) +: 8];
                n++;
                if (escape_en && din[8*(NB-1-i) +: 8] == ESC_BYTE) begin
                    exp_bytes[8*(2*NB-1-n) +: 8] = STUFF_BYTE;
                    n++;
                    s++;
                end
            end
        end
    end
    assign add_cnt   = AW'(n);
    assign stuff_cnt = SW'(s);
endmodule

// File: rtl/bit_stuffer_escape_par.sv
// bit_stuffer_escape_par: NB-byte escape stuffer with byte buffer, ready/valid handshakes and flush
module bit_stuffer_escape_par
    import compressor_jp_pkg::*;
#(
    parameter int NB = 4,
    parameter logic [7:0] ESC_BYTE = ESC_BYTE_DEF,
    parameter logic [7:0] STUFF_BYTE = STUFF_BYTE_DEF,
    parameter int CNT_WIDTH = 16,
    localparam int BW = clog2(NB)
) (
    input  logic                 xclk,
    input  logic                 rst,
    input  logic [8*NB-1:0]      din,
    input  logic [BW-1:0]        bytes_in,
    input  logic                 escape_en,
    input  logic                 flush_in,
    input  logic                 in_stb,
    output logic                 in_rdy,
    output logic [8*NB-1:0]      d_out,
    output logic [BW-1:0]        bytes_out,
    output logic                 dv,
    input  logic                 out_rdy,
    output logic                 flush_out,
    output logic [CNT_WIDTH-1:0] esc_cnt
);
    localparam int LW  = clog2(3*NB+1);
    localparam int AW  = clog2(2*NB+1);
    localparam int SW  = clog2(NB+1);
    localparam int CW1 = CNT_WIDTH + 1;

    logic [24*NB-1:0]     buf_q, buf_d;
    logic [LW-1:0]        lvl_q, lvl_d, rem_w;
    logic [8*NB-1:0]      d_out_q, d_out_d;
    logic [BW-1:0]        bytes_out_q, bytes_out_d;
    logic                 dv_q, dv_d, full_w, take_w, push_w;
    logic [CNT_WIDTH-1:0] esc_cnt_q, esc_cnt_d;
    logic [CNT_WIDTH:0]   sum_w;
    flush_st_e            st_q, st_d;
    logic [16*NB-1:0]     exp_w;
    logic [AW-1:0]        add_w;
    logic [SW-1:0]        stf_w;

    bit_stuffer_escape_expand #(.NB(NB), .ESC_BYTE(ESC_BYTE), .STUFF_BYTE(STUFF_BYTE)) u_expand (
        .din(din), .bytes_in(bytes_in), .escape_en(escape_en),
        .exp_bytes(exp_w), .add_cnt(add_w), .stuff_cnt(stf_w)
    );

    assign in_rdy = (lvl_q <= LW'(NB)) && (st_q == FS_IDLE);
    assign push_w = in_stb && in_rdy && !flush_in;

    // Buffer is kept MSB aligned with zeros below lvl, so extraction is a left shift and append an OR
    always_comb begin
        full_w = lvl_q >= LW'(NB);
        take_w = (!dv_q || out_rdy) && (full_w || (st_q == FS_FLUSH && lvl_q != '0));
        rem_w = take_w ? (full_w ? LW'(NB) : lvl_q) : '0;
        buf_d = (buf_q << (8 * rem_w)) |
                (push_w ? ({exp_w, {(8*NB){1'b0}}} >> (8 * (lvl_q - rem_w))) : '0);
        lvl_d = lvl_q - rem_w + (push_w ? LW'(add_w) : '0);
        dv_d = (!dv_q || out_rdy) ? take_w : dv_q;
        d_out_d = take_w ? buf_q[24*NB-1 -: 8*NB] : d_out_q;
        bytes_out_d = take_w ? (full_w ? '0 : BW'(lvl_q)) : bytes_out_q;
        sum_w = {1'b0, esc_cnt_q} + (push_w ? CW1'(stf_w) : '0);
        esc_cnt_d = sum_w[CNT_WIDTH] ? '1 : sum_w[CNT_WIDTH-1:0];
        st_d = (st_q == FS_IDLE)  ? ((flush_in && in_stb && in_rdy) ? FS_FLUSH : FS_IDLE) :
               (st_q == FS_FLUSH) ? ((lvl_q == '0 && (!dv_q || out_rdy)) ? FS_DONE : FS_FLUSH) :
                                    FS_IDLE;
    end

    always_ff @(posedge xclk) begin
        if (rst) begin
            buf_q       <= '0;
            lvl_q       <= '0;
            dv_q        <= 1'b0;
            d_out_q     <= '0;
            bytes_out_q <= '0;
            esc_cnt_q   <= '0;
            st_q        <= FS_IDLE;
        end else begin
            buf_q       <= buf_d;
            lvl_q       <= lvl_d;
            dv_q        <= dv_d;
            d_out_q     <= d_out_d;
            bytes_out_q <= bytes_out_d;
            esc_cnt_q   <= esc_cnt_d;
            st_q        <= st_d;
        end
    end

    assign dv        = dv_q;
    assign d_out     = d_out_q;
    assign bytes_out = bytes_out_q;
    assign esc_cnt   = esc_cnt_q;
    assign flush_out = st_q == FS_DONE;
endmodule

// File: doc/bit_stuffer_escape_par.md
Name: bit_stuffer_escape_par

Overview:
Parametrised successor of the JPEG 0xFF byte-stuffing escaper. It takes NB-byte MSB-aligned words from the entropy coder and inserts STUFF_BYTE after every ESC_BYTE. It emits NB-byte words with ready/valid backpressure on both sides, has a per-word escape bypass and a saturating stuffed-byte counter. It sits between the bit packer and the compressed-data output FIFO.

Parameters:
NB, 4, bytes per input/output word (2..8)
ESC_BYTE, 8'hff, byte value that triggers stuffing
STUFF_BYTE, 8'h00, byte inserted after each ESC_BYTE
CNT_WIDTH, 16, width of esc_cnt

Ports:
xclk  in  1  clock, all logic @posedge
rst  in  1  reset, synchronous, active-high
din  in  8*NB  input word, MSB aligned
bytes_in  in  clog2(NB)  valid bytes in din, 0 means NB
escape_en  in  1  1 = stuff this word, 0 = pass it unchanged; sampled with the word
flush_in  in  1  end of stream, qualified by in_stb; din ignored
in_stb  in  1  input strobe; transfer = in_stb && in_rdy
in_rdy  out  1  block can accept a word
d_out  out  8*NB  output word, MSB aligned
bytes_out  out  clog2(NB)  valid bytes in d_out, 0 means NB; meaningful only with dv
dv  out  1  output valid
out_rdy  in  1  downstream accepts; transfer = dv && out_rdy
flush_out  out  1  one-cycle pulse after the last flushed word is transferred
esc_cnt  out  CNT_WIDTH  stuffed bytes inserted since reset, saturating

Behaviour:
- Reset values: in_rdy=1, dv=0, d_out=0, bytes_out=0, flush_out=0, esc_cnt=0. Byte buffer is emptied and the flush state goes to IDLE.
- Byte buffer: capacity 3*NB bytes, byte granular, with level counter `lvl`.
  - An accepted word appends its valid bytes MSB first.
  - If escape_en=1, each ESC_BYTE is followed by STUFF_BYTE.
  - A word may expand to at most 2*NB bytes.
- in_rdy = (lvl <= NB) && (fsm == IDLE). It is a registered-state function only, with no combinational path from out_rdy.
- Output register:
  - Loads when (!dv || out_rdy) and either lvl >= NB, or the FSM is in FLUSH and 0 < lvl < NB.
  - A full load takes the top NB bytes and gives bytes_out=0.
  - A partial load is MSB aligned, lower lanes are zeroed, and bytes_out=lvl.
  - d_out and bytes_out are held stable while dv && !out_rdy.
- Latency: a word accepted in cycle N with lvl=0 and 0 escapes gives dv=1 in cycle N+2 (stage 1 expand/append, stage 2 output register).
- A stuff byte generated by an ESC_BYTE in the last lane of an output word goes into the next output word. Escape pairs are never dropped or reordered.
- Simultaneous append and extract in the same cycle are allowed; lvl_next = lvl + added - removed.
- esc_cnt increments by the number of stuffed bytes per accepted word and saturates at all ones.
- FSM states:
  - IDLE: on flush_in && in_stb && in_rdy, go to FLUSH. No data is appended from that beat.
  - FLUSH: in_rdy=0. Drain the buffer through full and then partial loads. When lvl==0 and (!dv || out_rdy), go to DONE.
  - DONE: flush_out=1 for one cycle, then go to IDLE.
- Flush with an empty buffer and dv=0 gives a flush_out pulse 2 cycles after the flush beat, with no dv.
- rst mid-stream or mid-flush discards all buffered data. The next cycle shows the reset values.

Decomposition:
- Shared package (compressor_jp_pkg): ESC/STUFF default constants and a clog2 function for port widths.
- One sub-module, bit_stuffer_escape_expand: combinational per-word expander. It takes din, bytes_in and escape_en, and produces an expanded 2*NB-byte MSB-aligned vector, an added-byte count and a stuffed-byte count.
- The top level holds the buffer, FSM, output register and counter.

Test Plan:
- NB=4; 0x12345678 then 0x9ABCDEF0, bytes_in=0, escape_en=1, out_rdy=1 -> d_out 0x12345678 then 0x9ABCDEF0, bytes_out=0, first dv 2 cycles after accept, esc_cnt=0.
- 0xFF00FF11, 0xAABBCCDD, then flush -> 0xFF0000FF, 0x0011AABB, 0xCCDD0000 with bytes_out=2, flush_out one cycle after the last transfer, esc_cnt=2.
- 0x112233FF then flush -> 0x112233FF, then 0x00000000 with bytes_out=1 (the carried stuff byte), then flush_out; esc_cnt=1.
- Stream of 0xFFFFFFFF with out_rdy=0 for 6 cycles -> in_rdy drops once lvl>NB, d_out is held stable, and after release exactly two 0xFF00FF00 words appear per accepted input with none lost.
- escape_en=0, 0xFFFFFFFF bytes_in=3 then flush -> 0xFFFFFF00 with bytes_out=3, esc_cnt unchanged.
- rst for 1 cycle while dv=1 and lvl=5 -> next cycle dv=0, in_rdy=1, esc_cnt=0, no flush_out; a following 0x01020304 emerges cleanly 2 cycles after accept.
